sort_floats_n_using_fsm: RTL and testbench
==========================================

Name: sort_floats_n_using_fsm

Overview:
- Sorts N floating-point numbers in ascending or descending order using an FSM-driven bubble sort.
- Issues exactly one comparison per cycle through a single external f_less_or_equal interface. The block instantiates no submodules.
- Generalises the three-element FSM sorter to any N ≥ 2 and adds a runtime direction select, a registered result with an out_ready backpressure handshake, and a sticky per-job error flag.
- FLEN is the global FP width from the shared cvw config header; FP64 is the usual value.

Parameters:
- N, 4: number of elements to sort; legal range is N ≥ 2.
- NCMP, N*(N-1)/2: comparisons per job. This is derived, not overridable.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- valid_in  input  1  job request; accepted only in S_IDLE
- descending  input  1  sort direction, sampled with valid_in: 0 = ascending, 1 = descending
- unsorted  input  [0:N-1][FLEN-1:0]  operands, sampled with valid_in
- busy  output  1  high in every state except S_IDLE
- valid_out  output  1  result valid; held high until out_ready
- out_ready  input  1  consumer accepts the result
- sorted  output  [0:N-1][FLEN-1:0]  registered result
- err  output  1  a comparison in this job reported f_le_err; qualified by valid_out
- f_le_a  output  FLEN  comparator operand a
- f_le_b  output  FLEN  comparator operand b
- f_le_res  input  1  result of (f_le_a <= f_le_b), combinational, same cycle
- f_le_err  input  1  comparator error (NaN operand), same cycle

Behaviour:
- **Reset values.** On rst: state = S_IDLE; busy = 0, valid_out = 0, err = 0, sorted = '0; work array, counters and direction register cleared. A reset mid-job discards the job with no valid_out.
- **States.** S_IDLE → S_SORT → S_DONE → S_IDLE.
- **S_IDLE.**
  - If valid_in: latch unsorted into array arr[0:N-1], latch descending, clear the job error, set pass p = 0 and index i = 0, then go to S_SORT.
  - Otherwise hold.
- **S_SORT.** One comparison per cycle on arr[i] and arr[i+1]:
  - Ascending: f_le_a = arr[i], f_le_b = arr[i+1].
  - Descending: f_le_a = arr[i+1], f_le_b = arr[i].
  - Swap rule: swap arr[i] and arr[i+1] at the clock edge iff f_le_res == 0. Equal elements are never swapped, so the sort is stable. When f_le_err = 1 the swap still follows f_le_res exactly as given.
  - Error: job error |= f_le_err.
  - Index advance: if i == N-2-p, then i = 0 and p = p+1; otherwise i = i+1.
  - Exit: after the comparison with p == N-2 and i == 0 (the NCMP-th comparison), load sorted from the final array (including that cycle's swap), load err from the job error with that cycle's f_le_err ORed in, and go to S_DONE.
- **S_DONE.**
  - valid_out = 1; sorted and err are held stable.
  - If out_ready: go to S_IDLE, and valid_out drops the next cycle.
  - sorted keeps its last value after the handshake until the next result loads.
- **Latency.** With valid_in sampled at edge T, the comparisons occupy cycles T+1..T+NCMP and valid_out rises at T+NCMP+1. For N = 4 that is 6 comparison cycles and valid_out at cycle T+7.
- **Throughput.** One job every NCMP+2 cycles with out_ready tied high.
- **Input while busy.** valid_in is ignored in S_SORT and S_DONE: no queueing and no corruption of the job in flight.
- **Idle comparator drive.** Outside S_SORT, f_le_a = f_le_b = '0; f_le_res and f_le_err are ignored.
- **Counters.** p and i are $clog2(N)-bit, or 1 bit when N = 2. With N = 2 there is one comparison and the FSM exits on the first S_SORT cycle.
- **Error scope.** err describes only the current job; it is cleared on acceptance, never carried between jobs.

Test Plan:
- **Ascending, N=4.** FP64 unsorted = {3.0, 1.0, 2.0, -0.5}, descending = 0, valid_in pulse at cycle 0 → exactly 6 comparator cycles; valid_out = 1 at cycle 7 with sorted = {-0.5, 1.0, 2.0, 3.0}, err = 0; busy = 1 on cycles 1-7.
- **Descending, N=4.** Same data with descending = 1 → sorted = {3.0, 2.0, 1.0, -0.5}. The first comparison drives f_le_a = 1.0, f_le_b = 3.0.
- **Stability and NaN.**
  - {+0.0, -0.0, 5.0, 5.0} ascending → output equals input order, err = 0.
  - Replace element 2 with a qNaN (comparator raises f_le_err) → valid_out at cycle 7 with err = 1.
  - The next clean job reports err = 0.
- **Backpressure.** Hold out_ready = 0 for 5 cycles after valid_out rises, and pulse valid_in with new data during that window → valid_out and sorted remain stable, the new request is ignored, and the FSM returns to S_IDLE one cycle after out_ready = 1.
- **Reset mid-job.** Assert rst at cycle 3 of a job → the next cycle shows busy = 0, valid_out = 0, err = 0, sorted = 0. A new job accepted afterwards completes with correct latency.
- **Parameter sweep.** Run random FP64 vectors with N = 2, 3, 8 against a reference model → result correct, and valid_out appears NCMP+1 cycles after acceptance (2, 4 and 29 cycles respectively).

Source files
------------

// File: rtl/sort_floats_n_using_fsm.sv
// Bubble-sorts N FLEN-bit floating-point values, ascending or descending,
// issuing one comparison per cycle to an external f_less_or_equal unit.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid_in          job request, accepted only when idle
//   descending        sort direction sampled with valid_in (1 = descending)
//   unsorted          N operands sampled with valid_in
//   busy              high whenever not idle
//   valid_out         result valid, held until out_ready
//   out_ready         consumer accepts the result
//   sorted            registered result array
//   err               some comparison of this job reported f_le_err
//   f_le_a, f_le_b    comparator operands (zero outside the sort phase)
//   f_le_res          comparator result (f_le_a <= f_le_b), same cycle
//   f_le_err          comparator error (NaN operand), same cycle
module sort_floats_n_using_fsm #(
    parameter int unsigned N    = 4,
    parameter int unsigned FLEN = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic                      descending,
    input  logic [0:N-1][FLEN-1:0]    unsorted,
    output logic                      busy,
    output logic                      valid_out,
    input  logic                      out_ready,
    output logic [0:N-1][FLEN-1:0]    sorted,
    output logic                      err,
    output logic [FLEN-1:0]           f_le_a,
    output logic [FLEN-1:0]           f_le_b,
    input  logic                      f_le_res,
    input  logic                      f_le_err
);

    // Pass and index counters; one bit is enough when N = 2.
    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state_q;
    logic [0:N-1][FLEN-1:0]     arr_q;
    logic [0:N-1][FLEN-1:0]     sorted_q;
    logic [CW-1:0]              p_q;
    logic [CW-1:0]              i_q;
    logic                       desc_q;
    logic                       jerr_q;
    logic                       busy_q;
    logic                       valid_q;
    logic                       err_q;

    logic [CW-1:0]              ip1;
    logic [FLEN-1:0]            lo;
    logic [FLEN-1:0]            hi;
    logic [0:N-1][FLEN-1:0]     arr_d;
    logic                       last_cmp;
    logic                       pass_end;
    logic                       in_sort;

    // Current pair, the array after this cycle's conditional swap, and the
    // pass/job end conditions. A false f_le_res means the pair is out of order.
    always_comb begin
        ip1      = i_q + CW'(1);
        lo       = arr_q[i_q];
        hi       = arr_q[ip1];
        arr_d    = arr_q;
        if (!f_le_res) begin
            arr_d[i_q] = hi;
            arr_d[ip1] = lo;
        end
        last_cmp = (p_q == CW'(N - 2)) && (i_q == '0);
        pass_end = (i_q == (CW'(N - 2) - p_q));
        in_sort  = (state_q == S_SORT);
    end

    // Descending order is obtained by swapping the comparator operands.
    assign f_le_a = in_sort ? (desc_q ? hi : lo) : '0;
    assign f_le_b = in_sort ? (desc_q ? lo : hi) : '0;

    // Sorter FSM with registered status and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            arr_q    <= '0;
            sorted_q <= '0;
            p_q      <= '0;
            i_q      <= '0;
            desc_q   <= 1'b0;
            jerr_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        arr_q   <= unsorted;
                        desc_q  <= descending;
                        jerr_q  <= 1'b0;
                        p_q     <= '0;
                        i_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SORT;
                    end
                end
                S_SORT: begin
                    arr_q  <= arr_d;
                    jerr_q <= jerr_q | f_le_err;
                    if (last_cmp) begin
                        sorted_q <= arr_d;
                        err_q    <= jerr_q | f_le_err;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (pass_end) begin
                        i_q <= '0;
                        p_q <= p_q + CW'(1);
                    end else begin
                        i_q <= ip1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign valid_out = valid_q;
    assign sorted    = sorted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sort_floats_n_using_fsm.sv
// Directed bench for sort_floats_n_using_fsm: N=4 behaviour plus N=2/3/8 sweeps.
module tb_sort_floats_n_using_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] P3  = 64'h4008000000000000;
    localparam logic [63:0] P1  = 64'h3FF0000000000000;
    localparam logic [63:0] P2  = 64'h4000000000000000;
    localparam logic [63:0] MH  = 64'hBFE0000000000000;
    localparam logic [63:0] PZ  = 64'h0000000000000000;
    localparam logic [63:0] NZ  = 64'h8000000000000000;
    localparam logic [63:0] P5  = 64'h4014000000000000;
    localparam logic [63:0] QN  = 64'h7FF8000000000000;

    // IEEE-754 binary64 a <= b; returns {err, res}. NaN gives err=1, res=0.
    function automatic logic [1:0] fle(input logic [63:0] a, input logic [63:0] b);
        logic na;
        logic nb;
        na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        if (na || nb) return 2'b10;
        if (a[62:0] == 63'd0 && b[62:0] == 63'd0) return 2'b01;
        if (a[63] != b[63]) return {1'b0, a[63]};
        if (!a[63]) return {1'b0, a[62:0] <= b[62:0]};
        return {1'b0, a[62:0] >= b[62:0]};
    endfunction

    // Reference: stable insertion sort on real values, packed element 0 first.
    function automatic logic [511:0] ref_sort(input logic [63:0] v[8], input int n, input bit desc);
        real a[8];
        real key;
        int j;
        logic [511:0] r;
        for (int k = 0; k < 8; k++) a[k] = $bitstoreal(v[k]);
        for (int k = 1; k < n; k++) begin
            key = a[k];
            j = k;
            while (j > 0 && (desc ? (a[j-1] < key) : (a[j-1] > key))) begin
                a[j] = a[j-1];
                j--;
            end
            a[j] = key;
        end
        r = '0;
        for (int k = 0; k < n; k++) r = (r << 64) | 512'($realtobits(a[k]));
        return r;
    endfunction

    // N = 4 instance
    logic                 valid4 = 1'b0, desc4 = 1'b0, ordy4 = 1'b1;
    logic [0:3][63:0]     uns4 = '0;
    logic [0:3][63:0]     sorted4;
    logic                 busy4, vo4, err4, res4, e4;
    logic [63:0]          a4, b4;
    always_comb {e4, res4} = fle(a4, b4);

    sort_floats_n_using_fsm #(.N(4), .FLEN(64)) dut4 (
        .clk(clk), .rst(rst), .valid_in(valid4), .descending(desc4), .unsorted(uns4),
        .busy(busy4), .valid_out(vo4), .out_ready(ordy4), .sorted(sorted4), .err(err4),
        .f_le_a(a4), .f_le_b(b4), .f_le_res(res4), .f_le_err(e4));

    // N = 2 / 3 / 8 instances for the sweep
    logic                 valid2 = 1'b0, valid3 = 1'b0, valid8 = 1'b0, descs = 1'b0;
    logic [0:1][63:0]     uns2 = '0, sorted2;
    logic [0:2][63:0]     uns3 = '0, sorted3;
    logic [0:7][63:0]     uns8 = '0, sorted8;
    logic                 busy2, vo2, err2, res2, e2;
    logic                 busy3, vo3, err3, res3, e3;
    logic                 busy8, vo8, err8, res8, e8;
    logic [63:0]          a2, b2, a3, b3, a8, b8;
    always_comb {e2, res2} = fle(a2, b2);
    always_comb {e3, res3} = fle(a3, b3);
    always_comb {e8, res8} = fle(a8, b8);

    sort_floats_n_using_fsm #(.N(2), .FLEN(64)) dut2 (
        .clk(clk), .rst(rst), .valid_in(valid2), .descending(descs), .unsorted(uns2),
        .busy(busy2), .valid_out(vo2), .out_ready(1'b1), .sorted(sorted2), .err(err2),
        .f_le_a(a2), .f_le_b(b2), .f_le_res(res2), .f_le_err(e2));
    sort_floats_n_using_fsm #(.N(3), .FLEN(64)) dut3 (
        .clk(clk), .rst(rst), .valid_in(valid3), .descending(descs), .unsorted(uns3),
        .busy(busy3), .valid_out(vo3), .out_ready(1'b1), .sorted(sorted3), .err(err3),
        .f_le_a(a3), .f_le_b(b3), .f_le_res(res3), .f_le_err(e3));
    sort_floats_n_using_fsm #(.N(8), .FLEN(64)) dut8 (
        .clk(clk), .rst(rst), .valid_in(valid8), .descending(descs), .unsorted(uns8),
        .busy(busy8), .valid_out(vo8), .out_ready(1'b1), .sorted(sorted8), .err(err8),
        .f_le_a(a8), .f_le_b(b8), .f_le_res(res8), .f_le_err(e8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one N=4 job with out_ready high; returns result and latency (cycles).
    task automatic run4(input logic [0:3][63:0] d, input logic dsc,
                        output logic [0:3][63:0] s, output logic e, output int lat);
        int c;
        uns4 = d; desc4 = dsc; valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        c = 1;
        while (!vo4 && c < 20) begin
            tick();
            c++;
        end
        lat = vo4 ? c : 0;
        s = sorted4;
        e = err4;
        tick();
    endtask

    logic [0:3][63:0] s4, hold4;
    logic             e4r;
    int               lat;
    logic [63:0]      v[8];
    int               l2, l3, l8;
    logic [511:0]     r2, r3, r8;
    logic             q2, q3, q8;

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", 512'(busy4), 512'(0));
        chk("reset_valid", 512'(vo4), 512'(0));
        chk("reset_err", 512'(err4), 512'(0));
        chk("reset_sorted", 512'(sorted4), 512'(0));
        chk("idle_f_le_a", 512'(a4), 512'(0));

        // Ascending, cycle-accurate
        uns4 = {P3, P1, P2, MH}; desc4 = 1'b0; valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        chk("asc_busy_c1", 512'(busy4), 512'(1));
        chk("asc_first_a", 512'(a4), 512'(P3));
        chk("asc_first_b", 512'(b4), 512'(P1));
        repeat (5) tick();
        chk("asc_valid_c6", 512'(vo4), 512'(0));
        chk("asc_busy_c6", 512'(busy4), 512'(1));
        tick();
        chk("asc_valid_c7", 512'(vo4), 512'(1));
        chk("asc_busy_c7", 512'(busy4), 512'(1));
        chk("asc_sorted", 512'(sorted4), 512'({MH, P1, P2, P3}));
        chk("asc_err", 512'(err4), 512'(0));
        tick();
        chk("asc_valid_c8", 512'(vo4), 512'(0));
        chk("asc_busy_c8", 512'(busy4), 512'(0));

        // Descending
        uns4 = {P3, P1, P2, MH}; desc4 = 1'b1; valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        chk("desc_first_a", 512'(a4), 512'(P1));
        chk("desc_first_b", 512'(b4), 512'(P3));
        repeat (6) tick();
        chk("desc_valid_c7", 512'(vo4), 512'(1));
        chk("desc_sorted", 512'(sorted4), 512'({P3, P2, P1, MH}));
        tick();

        // Stability, NaN error, error cleared on the next job
        run4({PZ, NZ, P5, P5}, 1'b0, s4, e4r, lat);
        chk("stable_sorted", 512'(s4), 512'({PZ, NZ, P5, P5}));
        chk("stable_err", 512'(e4r), 512'(0));
        run4({PZ, NZ, QN, P5}, 1'b0, s4, e4r, lat);
        chk("nan_latency", 512'(lat), 512'(7));
        chk("nan_err", 512'(e4r), 512'(1));
        run4({PZ, NZ, P5, P5}, 1'b0, s4, e4r, lat);
        chk("after_nan_err", 512'(e4r), 512'(0));

        // Backpressure with a request arriving while the result is held
        ordy4 = 1'b0;
        uns4 = {P2, MH, P3, P1}; desc4 = 1'b0; valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        repeat (6) tick();
        chk("bp_valid_rise", 512'(vo4), 512'(1));
        chk("bp_sorted", 512'(sorted4), 512'({MH, P1, P2, P3}));
        hold4 = sorted4;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                uns4 = {P5, P5, P5, P5}; desc4 = 1'b1; valid4 = 1'b1;
            end
            if (k == 2) valid4 = 1'b0;
            tick();
            chk("bp_valid_held", 512'(vo4), 512'(1));
            chk("bp_sorted_held", 512'(sorted4), 512'(hold4));
        end
        ordy4 = 1'b1;
        tick();
        chk("bp_release_valid", 512'(vo4), 512'(0));
        chk("bp_release_busy", 512'(busy4), 512'(0));
        tick();
        chk("bp_ignored_req", 512'(busy4), 512'(0));
        chk("bp_sorted_kept", 512'(sorted4), 512'({MH, P1, P2, P3}));

        // Reset in the middle of a job
        uns4 = {P3, P1, P2, MH}; desc4 = 1'b0; valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 512'(busy4), 512'(0));
        chk("rst_mid_valid", 512'(vo4), 512'(0));
        chk("rst_mid_err", 512'(err4), 512'(0));
        chk("rst_mid_sorted", 512'(sorted4), 512'(0));
        run4({P1, MH, P5, P2}, 1'b1, s4, e4r, lat);
        chk("rst_after_latency", 512'(lat), 512'(7));
        chk("rst_after_sorted", 512'(s4), 512'({P5, P2, P1, MH}));

        // Random sweep over N = 2, 3, 8 run side by side
        for (int job = 0; job < 3; job++) begin
            for (int k = 0; k < 8; k++)
                v[k] = $realtobits((real'($urandom_range(0, 4000)) - 2000.0) / 16.0);
            descs = 1'($urandom_range(0, 1));
            uns2 = {v[0], v[1]};
            uns3 = {v[0], v[1], v[2]};
            uns8 = {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
            valid2 = 1'b1; valid3 = 1'b1; valid8 = 1'b1;
            tick();
            valid2 = 1'b0; valid3 = 1'b0; valid8 = 1'b0;
            chk("sweep_busy_n8", 512'(busy8), 512'(1));
            l2 = 0; l3 = 0; l8 = 0;
            r2 = '0; r3 = '0; r8 = '0;
            q2 = 1'b1; q3 = 1'b1; q8 = 1'b1;
            for (int c = 1; c <= 40; c++) begin
                if (vo2 && l2 == 0) begin l2 = c; r2 = 512'(sorted2); q2 = err2; end
                if (vo3 && l3 == 0) begin l3 = c; r3 = 512'(sorted3); q3 = err3; end
                if (vo8 && l8 == 0) begin l8 = c; r8 = 512'(sorted8); q8 = err8; end
                if (c == 1 && !(busy2 && busy3)) begin
                    chk("sweep_busy_small", 512'({busy2, busy3}), 512'(2'b11));
                end
                tick();
            end
            chk("sweep_lat_n2", 512'(l2), 512'(2));
            chk("sweep_lat_n3", 512'(l3), 512'(4));
            chk("sweep_lat_n8", 512'(l8), 512'(29));
            chk("sweep_sorted_n2", r2, ref_sort(v, 2, descs));
            chk("sweep_sorted_n3", r3, ref_sort(v, 3, descs));
            chk("sweep_sorted_n8", r8, ref_sort(v, 8, descs));
            chk("sweep_err", 512'({q2, q3, q8}), 512'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
